rv_timer: RTL and testbench

Memory-mapped machine timer peripheral that sits on the system arilla bus as a slave next to `memory`. It provides a 64-bit `mtime` counter advanced by a programmable prescaler, a 64-bit `mtimecmp` compare register, and a level machine-timer interrupt toward `rv_core`. Registered reads return data one cycle after the request. Address decode is done locally, and the block drives `intercept` for its own address window.

---
 rtl/rv_timer_if.sv | 23 ++
 rtl/rv_timer.sv | 138 +++++++++++++
 tb/tb_rv_timer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_timer_if.sv
// Bus port bundle for the rv_timer slave. The master drives the request
// fields. The slave returns the registered read data, the read-valid pulse
// and the combinational intercept flag.
interface rv_timer_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic [31:0] read_data;
  logic        read_valid;
  logic        intercept;

  modport master (
    output address, read, write, write_data, byte_enable,
    input  read_data, read_valid, intercept
  );

  modport slave (
    input  address, read, write, write_data, byte_enable,
    output read_data, read_valid, intercept
  );
endinterface

// File: rtl/rv_timer.sv
// rv_timer: memory-mapped 64-bit machine timer.
// It holds mtime, which a prescaler advances, and mtimecmp. It also holds a
// ctrl register (en, ie), a hi-word snapshot for tear-free 64-bit reads, and
// a registered level interrupt. Reads return data one cycle after the request.
module rv_timer #(
  parameter logic [31:0] BaseAddress = 32'hFFFF_0000,
  parameter int          Prescaler   = 50
) (
  input  logic       clk,
  input  logic       rst,
  rv_timer_if.slave  bus,
  output logic       timer_irq
);

  localparam int            PW     = (Prescaler > 1) ? $clog2(Prescaler) : 1;
  localparam logic [PW-1:0] PreMax = PW'(Prescaler - 1);

  localparam logic [2:0] OffMLo   = 3'd0;
  localparam logic [2:0] OffMHi   = 3'd1;
  localparam logic [2:0] OffCLo   = 3'd2;
  localparam logic [2:0] OffCHi   = 3'd3;
  localparam logic [2:0] OffCtrl  = 3'd4;
  localparam logic [2:0] OffStat  = 3'd5;
  localparam logic [2:0] OffSnap  = 3'd6;

  logic [63:0]   r_mtime;
  logic [63:0]   r_cmp;
  logic [1:0]    r_ctrl;      // [0]=en, [1]=ie
  logic [PW-1:0] r_pre;
  logic [31:0]   r_snap;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_irq;

  logic          w_hit;
  logic [2:0]    w_off;
  logic          w_wr;
  logic          w_rd;
  logic          w_tick;
  logic          w_pending;
  logic [31:0]   w_rmux;
  logic [31:0]   w_merged;
  logic          w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  assign w_hit  = (bus.address[31:5] == BaseAddress[31:5]);
  assign w_off  = bus.address[4:2];
  // A write with no byte lanes counts as no write, so it cannot steal a tick.
  // It still suppresses a simultaneous read.
  assign w_wr   = w_hit & bus.write & (|bus.byte_enable);
  assign w_rd   = w_hit & bus.read & ~bus.write;
  assign w_tick = r_ctrl[0] & (r_pre == PreMax);
  assign w_pending = (r_mtime >= r_cmp);
  assign w_unused  = ^bus.address[1:0];

  assign bus.intercept  = w_hit & (bus.read | bus.write);
  assign bus.read_data  = r_rdata;
  assign bus.read_valid = r_rvalid;
  assign timer_irq      = r_irq;

  // Register read mux. It also supplies the old value for byte-lane merges.
  always_comb begin
    w_rmux = 32'd0;
    case (w_off)
      OffMLo:  w_rmux = r_mtime[31:0];
      OffMHi:  w_rmux = r_mtime[63:32];
      OffCLo:  w_rmux = r_cmp[31:0];
      OffCHi:  w_rmux = r_cmp[63:32];
      OffCtrl: w_rmux = {30'd0, r_ctrl};
      OffStat: w_rmux = {31'd0, w_pending};
      OffSnap: w_rmux = r_snap;
      default: w_rmux = 32'd0;
    endcase
  end

  assign w_merged = f_merge(w_rmux, bus.write_data, bus.byte_enable);

  // Prescaler: count 0..Prescaler-1 while enabled, park at 0 when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_pre <= '0;
    else if (!r_ctrl[0])  r_pre <= '0;
    else if (w_tick)      r_pre <= '0;
    else                  r_pre <= r_pre + 1'b1;
  end

  // mtime: a bus write to either half overrides (and drops) a coincident tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_mtime <= 64'd0;
    else if (w_wr && w_off == OffMLo) r_mtime[31:0]  <= w_merged;
    else if (w_wr && w_off == OffMHi) r_mtime[63:32] <= w_merged;
    else if (w_tick)                  r_mtime <= r_mtime + 64'd1;
  end

  // mtimecmp and ctrl writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp  <= '1;
      r_ctrl <= 2'b00;
    end else if (w_wr) begin
      if (w_off == OffCLo)  r_cmp[31:0]  <= w_merged;
      if (w_off == OffCHi)  r_cmp[63:32] <= w_merged;
      if (w_off == OffCtrl) r_ctrl       <= w_merged[1:0];
    end
  end

  // Latch hi alongside a lo read so a later snap read pairs with that lo
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_snap <= 32'd0;
    else if (w_rd && w_off == OffMLo) r_snap <= r_mtime[63:32];
  end

  // Read response: one-cycle valid pulse; data holds between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rmux;
    end
  end

  // Level interrupt from the current register state, so it lags by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_ctrl[1] & w_pending;
  end

endmodule

// File: tb/tb_rv_timer.sv
// Self-checking bench for rv_timer. Expected read data goes into a
// scoreboard queue when a read is issued. It is popped and compared when
// the response arrives.
module tb_rv_timer;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] MLO   = BASE + 32'h00;
  localparam logic [31:0] MHI   = BASE + 32'h04;
  localparam logic [31:0] CLO   = BASE + 32'h08;
  localparam logic [31:0] CHI   = BASE + 32'h0C;
  localparam logic [31:0] CTRL  = BASE + 32'h10;
  localparam logic [31:0] STAT  = BASE + 32'h14;
  localparam logic [31:0] SNAP  = BASE + 32'h18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timer_irq;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] sb[$];

  rv_timer_if bus();

  rv_timer #(.BaseAddress(BASE), .Prescaler(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.address = a; bus.write = 1'b1; bus.write_data = d; bus.byte_enable = be;
    @(negedge clk);
    bus.write = 1'b0; bus.byte_enable = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    v = bus.read_valid;
    d = bus.read_data;
  endtask

  task automatic test_reset;
    logic [31:0] exp_t [8];
    logic [31:0] e;
    exp_t = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    n_checks++;
    if (timer_irq !== 1'b0 || bus.read_valid !== 1'b0 || bus.read_data !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs irq=%b valid=%b data=%h required 0/0/0",
               timer_irq, bus.read_valid, bus.read_data);
    end
    // back-to-back reads of every offset, one per cycle
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (bus.read_valid !== 1'b1 || bus.read_data !== e) begin
          n_errors++;
          $display("FAIL reset_read[%0d] valid=%b data=%h required 1/%h",
                   i - 1, bus.read_valid, bus.read_data, e);
        end
      end
      if (i < 8) begin
        bus.address = BASE + 32'(4 * i); bus.read = 1'b1;
        sb.push_back(exp_t[i]);
      end else bus.read = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bus.read_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid_tail valid=%b required 0", bus.read_valid);
    end
  endtask

  task automatic test_count;
    logic [31:0] d, e; logic v;
    bus_wr(CTRL, 0, 4'hF); bus_wr(MLO, 0, 4'hF); bus_wr(MHI, 0, 4'hF);
    bus_wr(CTRL, 1, 4'hF);
    repeat (499) @(negedge clk);
    sb.push_back(32'd10);
    bus_rd(MLO, d, v);
    e = sb.pop_front();
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_errors++; $display("FAIL count_500 valid=%b data=%h required 1/%h", v, d, e);
    end
    bus_wr(CTRL, 0, 4'hF);
    repeat (100) @(negedge clk);
    sb.push_back(32'd10);
    bus_rd(MLO, d, v);
    e = sb.pop_front();
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_errors++; $display("FAIL count_frozen valid=%b data=%h required 1/%h", v, d, e);
    end
  endtask

  task automatic test_carry;
    logic [31:0] d, e; logic v;
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    addrs = '{MLO, MHI, SNAP, MLO};
    exps  = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0};
    bus_wr(CTRL, 0, 4'hF); bus_wr(MLO, 32'hFFFF_FFFF, 4'hF); bus_wr(MHI, 0, 4'hF);
    bus_wr(CTRL, 1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) repeat (50) @(negedge clk);
      sb.push_back(exps[i]);
      bus_rd(addrs[i], d, v);
      e = sb.pop_front();
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_errors++; $display("FAIL carry[%0d] valid=%b data=%h required 1/%h", i, v, d, e);
      end
    end
    bus_wr(CTRL, 0, 4'hF);
  endtask

  task automatic test_irq;
    logic [31:0] d, e; logic v;
    bus_wr(CTRL, 0, 4'hF); bus_wr(MLO, 0, 4'hF); bus_wr(MHI, 0, 4'hF);
    bus_wr(CHI, 0, 4'hF); bus_wr(CLO, 20, 4'hF);
    bus_wr(CTRL, 3, 4'hF);
    for (int c = 1; c <= 1001; c++) begin
      @(negedge clk);
      if (c == 1000 || c == 1001) begin
        n_checks++;
        if (timer_irq !== (c == 1001)) begin
          n_errors++; $display("FAIL irq_rise_c%0d irq=%b required %b", c, timer_irq, c == 1001);
        end
      end
    end
    sb.push_back(32'h1);
    bus_rd(STAT, d, v);
    e = sb.pop_front();
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_errors++; $display("FAIL irq_status valid=%b data=%h required 1/%h", v, d, e);
    end
    bus_wr(CHI, 1, 4'hF);
    n_checks++;
    if (timer_irq !== 1'b1) begin
      n_errors++; $display("FAIL irq_hold irq=%b required 1", timer_irq);
    end
    @(negedge clk);
    n_checks++;
    if (timer_irq !== 1'b0) begin
      n_errors++; $display("FAIL irq_drop irq=%b required 0", timer_irq);
    end
    bus_wr(CTRL, 0, 4'hF);
  endtask

  task automatic test_byte_lane;
    logic [31:0] d, e; logic v;
    bus_wr(CLO, 32'hFFFF_FFFF, 4'hF);
    bus_wr(CLO, 32'hAABB_CCDD, 4'b0010);
    sb.push_back(32'hFFFF_CCFF);
    bus_rd(CLO, d, v);
    e = sb.pop_front();
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_errors++; $display("FAIL byte_lane valid=%b data=%h required 1/%h", v, d, e);
    end
    bus_wr(CLO, 32'h0, 4'h0);
    sb.push_back(32'hFFFF_CCFF);
    bus_rd(CLO, d, v);
    e = sb.pop_front();
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_errors++; $display("FAIL be_zero valid=%b data=%h required 1/%h", v, d, e);
    end
  endtask

  task automatic test_collision;
    logic [31:0] d, e; logic v;
    @(negedge clk);
    bus.address = CLO; bus.read = 1'b1; bus.write = 1'b1;
    bus.write_data = 32'h1234_5678; bus.byte_enable = 4'hF;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0; bus.byte_enable = 4'h0;
    n_checks++;
    if (bus.read_valid !== 1'b0) begin
      n_errors++; $display("FAIL collision_valid valid=%b required 0", bus.read_valid);
    end
    sb.push_back(32'h1234_5678);
    bus_rd(CLO, d, v);
    e = sb.pop_front();
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_errors++; $display("FAIL collision_write valid=%b data=%h required 1/%h", v, d, e);
    end
  endtask

  task automatic test_window;
    logic [31:0] e;
    @(negedge clk);
    bus.address = 32'h0000_0008; bus.read = 1'b1;
    #1;
    n_checks++;
    if (bus.intercept !== 1'b0) begin
      n_errors++; $display("FAIL miss_intercept intercept=%b required 0", bus.intercept);
    end
    @(negedge clk);
    bus.read = 1'b0;
    n_checks++;
    if (bus.read_valid !== 1'b0) begin
      n_errors++; $display("FAIL miss_valid valid=%b required 0", bus.read_valid);
    end
    bus.address = CLO;
    #1;
    n_checks++;
    if (bus.intercept !== 1'b0) begin
      n_errors++; $display("FAIL idle_intercept intercept=%b required 0", bus.intercept);
    end
    @(negedge clk);
    bus.read = 1'b1;
    sb.push_back(32'h1234_5678);
    #1;
    n_checks++;
    if (bus.intercept !== 1'b1) begin
      n_errors++; $display("FAIL hit_intercept intercept=%b required 1", bus.intercept);
    end
    @(negedge clk);
    bus.read = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.read_valid !== 1'b1 || bus.read_data !== e) begin
      n_errors++; $display("FAIL hit_read valid=%b data=%h required 1/%h",
                           bus.read_valid, bus.read_data, e);
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d, e; logic v;
    logic [31:0] addrs [7];
    logic [31:0] exps  [7];
    addrs = '{MLO, MHI, CLO, CHI, CTRL, STAT, SNAP};
    exps  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    bus_wr(MHI, 32'h7, 4'hF); bus_wr(MLO, 32'h5, 4'hF);
    bus_wr(CHI, 0, 4'hF); bus_wr(CLO, 0, 4'hF); bus_wr(CTRL, 3, 4'hF);
    @(negedge clk);
    n_checks++;
    if (timer_irq !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset_irq irq=%b required 1", timer_irq);
    end
    bus.address = MLO; bus.read = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; bus.read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.read_valid !== 1'b0 || bus.read_data !== 32'h0 || timer_irq !== 1'b0) begin
      n_errors++; $display("FAIL reset_drop valid=%b data=%h irq=%b required 0/0/0",
                           bus.read_valid, bus.read_data, timer_irq);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(exps[i]);
      bus_rd(addrs[i], d, v);
      e = sb.pop_front();
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_errors++; $display("FAIL post_reset[%0d] valid=%b data=%h required 1/%h", i, v, d, e);
      end
    end
  endtask

  initial begin
    bus.address = 32'h0; bus.read = 1'b0; bus.write = 1'b0;
    bus.write_data = 32'h0; bus.byte_enable = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_count();
    test_carry();
    test_irq();
    test_byte_lane();
    test_collision();
    test_window();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
